// File: rtl/counter_read_latch.sv
// counter_read_latch
//   Host-facing read-back path for one 8254 counter. Either follows the live
//   count from the counter core or holds a latched snapshot, optionally holds
//   a latched status byte, and serves one byte per qualified read strobe in
//   the LSB/MSB order selected by the RW mode.
//
// Ports
//   clk               system clock, all state changes on the rising edge
//   rst_n             asynchronous active-low reset
//   counter_selector  high when the bus interface addresses this counter
//   mode_write        1-cycle pulse: control word written to this counter
//   rw_mode[1:0]      01 LSB only, 10 MSB only, 11 LSB then MSB, 00 invalid
//   mode[2:0]         counter mode, reported in the status byte
//   bcd               BCD flag, reported in the status byte
//   count_value       live count from the counter core
//   out_state         current counter OUT pin level
//   null_count        new count written but not yet loaded into the core
//   latch_cmd         1-cycle pulse: counter-latch command
//   status_latch_cmd  1-cycle pulse: read-back status latch command
//   rd_stb            1-cycle read pulse, already synchronous to clk
//   data_out[7:0]     byte returned by a read in this cycle (combinational)
//   count_latched     high while a latched count is held
//   status_latched    high while a latched status byte is held
module counter_read_latch #(
  parameter int   COUNT_W   = 16,
  parameter logic RESET_MSB = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               counter_selector,
  input  logic               mode_write,
  input  logic [1:0]         rw_mode,
  input  logic [2:0]         mode,
  input  logic               bcd,
  input  logic [COUNT_W-1:0] count_value,
  input  logic               out_state,
  input  logic               null_count,
  input  logic               latch_cmd,
  input  logic               status_latch_cmd,
  input  logic               rd_stb,
  output logic [7:0]         data_out,
  output logic               count_latched,
  output logic               status_latched
);

  typedef enum logic {FOLLOW = 1'b0, LATCHED = 1'b1} count_state_t;

  localparam logic [1:0] RW_LSB  = 2'b01;
  localparam logic [1:0] RW_MSB  = 2'b10;
  localparam logic [1:0] RW_BOTH = 2'b11;

  count_state_t       count_state;
  logic [COUNT_W-1:0] out_latch;
  logic               byte_ptr;     // 0 = LSB next, 1 = MSB next (RW=11 only)
  logic [7:0]         status_byte;
  logic               status_held;

  // Commands and reads only count when this counter is addressed.
  logic rd, mode_wr, latch_req, status_req;
  assign rd         = rd_stb & counter_selector;
  assign mode_wr    = mode_write & counter_selector;
  assign latch_req  = latch_cmd & counter_selector;
  assign status_req = status_latch_cmd & counter_selector;

  // A held status byte shadows the count; that read leaves the count path alone.
  logic count_rd;
  assign count_rd = rd & ~status_held;

  // The last byte of the current RW sequence has been consumed by this read.
  // RW=00 has no bytes to deliver, so any count read ends the sequence.
  logic seq_done;
  assign seq_done = count_rd & ((rw_mode != RW_BOTH) | byte_ptr);

  // After this edge the count path is free to follow or re-latch.
  logic free_next;
  assign free_next = (count_state == FOLLOW) | seq_done;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_state <= FOLLOW;
      out_latch   <= '0;
      byte_ptr    <= RESET_MSB;
      status_byte <= 8'h00;
      status_held <= 1'b0;
    end else if (mode_wr) begin
      // A control word restarts the read sequence from scratch.
      count_state <= FOLLOW;
      out_latch   <= count_value;
      byte_ptr    <= RESET_MSB;
      status_held <= 1'b0;
    end else begin
      if (count_rd && rw_mode == RW_BOTH) begin
        byte_ptr <= ~byte_ptr;
      end

      // The read consumes the presented byte first; a latch command on the
      // same edge then captures the current count.
      if (free_next) begin
        out_latch   <= count_value;
        count_state <= latch_req ? LATCHED : FOLLOW;
      end

      if (status_held) begin
        if (rd) begin
          status_held <= 1'b0;
        end
      end else if (status_req) begin
        status_byte <= {out_state, null_count, rw_mode, mode, bcd};
        status_held <= 1'b1;
      end
    end
  end

  // NOTE: every branch of this case assigns data_out and a default precedes
  // it, so no latch is inferred.
  always_comb begin
    data_out = 8'h00;
    if (status_held) begin
      data_out = status_byte;
    end else begin
      unique case (rw_mode)
        RW_LSB:  data_out = out_latch[7:0];
        RW_MSB:  data_out = out_latch[15:8];
        RW_BOTH: data_out = byte_ptr ? out_latch[15:8] : out_latch[7:0];
        default: data_out = 8'h00;
      endcase
    end
  end

  assign count_latched  = (count_state == LATCHED);
  assign status_latched = status_held;

endmodule
